// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side controller.
// Combinational only; no latency, no backpressure.
package fifo_ctrl_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester after last_grant.
// Purely combinational; zero latency, no backpressure.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int idx;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    idx       = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin sharing of the FIFO write port; owns write pointers and full.
// One IDLE arbitration cycle per frame, then one beat per cycle; ready drops while full.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int PTR_LEN = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [PTR_LEN:0]           rd_ptr_sync,
  output logic                       wr_en,
  output logic [WIDTH-1:0]           wr_data,
  output logic [PTR_LEN:0]           wrt_ptr,
  output logic [PTR_LEN:0]           wrt_ptr_gray,
  output logic                       full,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [FRAME_CNT_W-1:0]     frame_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = PTR_LEN + 1;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]     gnt_oh_q, gnt_oh_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d, wgray_q, wgray_d, wptr_inc;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   busy_q, busy_d;
  logic [NUM_REQ-1:0]     arb_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   beat;
  logic [WIDTH-1:0]       data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_oh),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  assign full = (wptr_q[PTR_LEN] != rd_ptr_sync[PTR_LEN]) &&
                (wptr_q[PTR_LEN-1:0] == rd_ptr_sync[PTR_LEN-1:0]);
  assign wptr_inc = wptr_q + PTR_W'(1);

  always_comb begin
    req_ready = (state_q == XFER && !full) ? gnt_oh_q : '0;
    beat      = |(req_valid & req_ready);
    wr_en     = beat;
    wr_data   = data_arr[grant_q];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gnt_oh_d     = gnt_oh_q;
    wptr_d       = wptr_q;
    wgray_d      = wgray_q;
    frame_cnt_d  = frame_cnt_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d  = arb_idx;
          gnt_oh_d = arb_oh;
          state_d  = XFER;
          busy_d   = 1'b1;
        end
      end
      XFER: begin
        if (beat) begin
          wptr_d  = wptr_inc;
          wgray_d = PTR_W'(bin2gray(32'(wptr_inc)));
          if (|(req_last & gnt_oh_q)) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            last_grant_d = grant_q;
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      gnt_oh_q     <= NUM_REQ'(1);
      wptr_q       <= '0;
      wgray_q      <= '0;
      frame_cnt_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gnt_oh_q     <= gnt_oh_d;
      wptr_q       <= wptr_d;
      wgray_q      <= wgray_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign wrt_ptr      = wptr_q;
  assign wrt_ptr_gray = wgray_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int PTR_LEN = 4;

  logic                     clk = 1'b0;
  logic                     srst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [PTR_LEN:0]         rd_ptr_sync;
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic [PTR_LEN:0]         wrt_ptr;
  logic [PTR_LEN:0]         wrt_ptr_gray;
  logic                     full;
  logic                     busy;
  logic [1:0]               grant_id;
  logic [15:0]              frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .PTR_LEN(PTR_LEN)) dut (
    .clk          (clk),
    .srst         (srst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rd_ptr_sync  (rd_ptr_sync),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wrt_ptr      (wrt_ptr),
    .wrt_ptr_gray (wrt_ptr_gray),
    .full         (full),
    .busy         (busy),
    .grant_id     (grant_id),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst        = 1'b1;
    req_valid   = '0;
    req_last    = '0;
    req_data    = '0;
    rd_ptr_sync = '0;
    cyc();
    cyc();
    srst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    int n, n2, stray, fullseen, gaperr, expg;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_wptr", wrt_ptr, 0);
    chk("rst_gray", wrt_ptr_gray, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_full", full, 0);

    // 3-beat frame from requester 0
    cyc();
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA1;
    @(negedge clk);
    chk("t1_idle_rdy", req_ready, 0);
    chk("t1_idle_wr", wr_en, 0);
    cyc();
    @(negedge clk);
    chk("t1_grant", grant_id, 0);
    chk("t1_rdy", req_ready, 4'b0001);
    chk("t1_b0", {wr_en, wr_data}, {1'b1, 8'hA1});
    cyc();
    req_data[7:0] = 8'hA2;
    @(negedge clk);
    chk("t1_b1", {wr_en, wr_data}, {1'b1, 8'hA2});
    cyc();
    req_data[7:0] = 8'hA3;
    req_last[0]   = 1'b1;
    @(negedge clk);
    chk("t1_b2", {wr_en, wr_data}, {1'b1, 8'hA3});
    cyc();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t1_wptr", wrt_ptr, 3);
    chk("t1_gray", wrt_ptr_gray, 2);
    chk("t1_frames", frame_cnt, 1);
    chk("t1_busy", busy, 0);
    chk("t1_wr_idle", wr_en, 0);

    // all requesters, single-beat frames held
    do_reset();
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      expg = k % 4;
      @(negedge clk);
      chk("t2_idle", {busy, wr_en}, 0);
      cyc();
      @(negedge clk);
      chk("t2_grant", grant_id, expg);
      chk("t2_beat", {wr_en, wr_data}, {1'b1, 8'h10 + 8'(expg)});
      cyc();
    end
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t2_wptr", wrt_ptr, 5);
    chk("t2_frames", frame_cnt, 5);

    // full with reader stalled
    do_reset();
    req_valid = 4'b0010;
    req_data[15:8] = 8'h55;
    @(negedge clk);
    cyc();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (wr_en) n++;
      cyc();
    end
    @(negedge clk);
    chk("t3_writes", n, 16);
    chk("t3_full", full, 1);
    chk("t3_wptr", wrt_ptr, 5'h10);
    chk("t3_rdy_drop", req_ready, 0);
    chk("t3_no_wr", wr_en, 0);
    stray = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      if (wr_en) stray++;
    end
    chk("t3_stray", stray, 0);
    cyc();
    rd_ptr_sync = 5'h04;
    n2 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_en) n2++;
      cyc();
    end
    @(negedge clk);
    chk("t3_resume", n2, 4);
    chk("t3_full2", full, 1);
    chk("t3_wptr2", wrt_ptr, 5'h14);

    // pointer wrap with reader lagging by 8
    do_reset();
    req_valid = 4'b0001;
    req_data[7:0] = 8'h77;
    @(negedge clk);
    cyc();
    n = 0;
    fullseen = 0;
    for (int i = 0; i < 40; i++) begin
      req_last[0] = (i == 39);
      rd_ptr_sync = (n >= 8) ? 5'(n - 8) : 5'd0;
      @(negedge clk);
      if (wr_en) n++;
      if (full) fullseen++;
      cyc();
    end
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t4_writes", n, 40);
    chk("t4_fullseen", fullseen, 0);
    chk("t4_wptr", wrt_ptr, 8);
    chk("t4_gray", wrt_ptr_gray, 5'h0C);
    chk("t4_frames", frame_cnt, 1);

    // gap in requester 2's frame while requester 3 waits
    do_reset();
    req_valid = 4'b1100;
    req_data  = {8'h33, 8'h22, 8'h00, 8'h00};
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t5_grant", grant_id, 2);
    chk("t5_b0", {wr_en, wr_data}, {1'b1, 8'h22});
    cyc();
    @(negedge clk);
    chk("t5_b1", wr_en, 1);
    cyc();
    req_valid[2] = 1'b0;
    gaperr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (grant_id != 2'd2 || req_ready[3] || wr_en) gaperr++;
      cyc();
    end
    chk("t5_gap", gaperr, 0);
    req_valid[2] = 1'b1;
    req_last[2]  = 1'b1;
    req_data[23:16] = 8'h2F;
    @(negedge clk);
    chk("t5_last", {wr_en, wr_data}, {1'b1, 8'h2F});
    cyc();
    req_valid[2] = 1'b0;
    req_last[2]  = 1'b0;
    @(negedge clk);
    chk("t5_idle", {busy, req_ready}, 0);
    cyc();
    @(negedge clk);
    chk("t5_grant3", grant_id, 3);
    chk("t5_rdy3", req_ready, 4'b1000);
    chk("t5_b3", {wr_en, wr_data}, {1'b1, 8'h33});
    chk("t5_wptr", wrt_ptr, 3);

    // reset mid-frame
    do_reset();
    req_valid = 4'b0010;
    req_data[15:8] = 8'h66;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t6_b0", wr_en, 1);
    cyc();
    @(negedge clk);
    chk("t6_b1", wr_en, 1);
    cyc();
    srst = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t6_wptr", wrt_ptr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rdy", req_ready, 0);
    chk("t6_frames", frame_cnt, 0);
    cyc();
    srst      = 1'b0;
    req_valid = 4'b0011;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t6_prio", grant_id, 0);
    chk("t6_rdy0", req_ready, 4'b0001);

    req_valid = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
